// File: rtl/useq_sequencer_if.sv
// ---------------------------------------------------------------------------
// useq_sequencer_if
//
// Bundle between the microcode sequencer and the rest of the TTL RISC-V core.
// It carries the per-instruction decode/sequencing inputs, the control word and
// status outputs, and the runtime microcode load port.
//
// Signals:
//   opcode, subop      decoded opcode / func3 index (stable while step >= 1)
//   cond_in            branch comparison result
//   stall_in           hold the current step (memory wait)
//   trap_in            abort the current instruction
//   ctrl               current control word
//   step               current step
//   cond_taken         a COND word is active and cond_in is high
//   ucode_fault        one-cycle pulse on step overflow
//   retire             one-cycle pulse when an instruction completes
//   instret            retired-instruction count
//   ucode_we/sel/addr/wdata  microcode table write port
//
// Modports:
//   master  the core side: drives decode, sequencing and load inputs
//   slave   the sequencer: drives the control word and status outputs
// ---------------------------------------------------------------------------
interface useq_sequencer_if #(
  parameter int CW        = 32,
  parameter int STEPS     = 8,
  parameter int OPC_W     = 5,
  parameter int SUB_W     = 3,
  parameter int INSTRET_W = 64
);
  localparam int STEP_W = $clog2(STEPS);

  logic [OPC_W-1:0]        opcode;
  logic [SUB_W-1:0]        subop;
  logic                    cond_in;
  logic                    stall_in;
  logic                    trap_in;
  logic [CW-1:0]           ctrl;
  logic [STEP_W-1:0]       step;
  logic                    cond_taken;
  logic                    ucode_fault;
  logic                    retire;
  logic [INSTRET_W-1:0]    instret;
  logic                    ucode_we;
  logic                    ucode_sel;
  logic [OPC_W+STEP_W-1:0] ucode_addr;
  logic [CW-1:0]           ucode_wdata;

  modport master (
    output opcode, subop, cond_in, stall_in, trap_in,
    output ucode_we, ucode_sel, ucode_addr, ucode_wdata,
    input  ctrl, step, cond_taken, ucode_fault, retire, instret
  );

  modport slave (
    input  opcode, subop, cond_in, stall_in, trap_in,
    input  ucode_we, ucode_sel, ucode_addr, ucode_wdata,
    output ctrl, step, cond_taken, ucode_fault, retire, instret
  );
endinterface

// File: rtl/useq_sequencer.sv
// ---------------------------------------------------------------------------
// useq_sequencer
//
// Microcode sequencer for the multi-cycle TTL RISC-V core. Each cycle it
// presents one control word selected by a step counter: step 0 is the common
// fetch word, later steps come from a writable main table indexed by
// {opcode, step}, optionally OR-merged with a sub table indexed by
// {subop, step}. The top four bits of every word steer the step counter:
//   [CW-1] INC    advance to the next step
//   [CW-2] RST    end the instruction (wins over INC)
//   [CW-3] COND   advance if cond_in, otherwise end the instruction
//   [CW-4] MERGE  OR the sub-table word into the main-table word
// COND takes precedence over INC/RST in the same word; a word with no
// sequencing bit holds the step (microcoded wait).
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset (tables are not reset)
//   bus    useq_sequencer_if.slave: decode/sequencing inputs, control word
//          and status outputs, microcode load port
//
// ctrl and cond_taken are combinational from the current step so that a
// step's word is valid in the same cycle as step. step, retire, ucode_fault
// and instret are registered.
// ---------------------------------------------------------------------------
module useq_sequencer #(
  parameter int            CW         = 32,
  parameter int            STEPS      = 8,
  parameter int            OPC_W      = 5,
  parameter int            SUB_W      = 3,
  parameter int            INSTRET_W  = 64,
  parameter logic [CW-1:0] FETCH_WORD = 32'h8000_0045
) (
  input logic               clk,
  input logic               reset,
  useq_sequencer_if.slave   bus
);

  localparam int STEP_W     = $clog2(STEPS);
  localparam int MAIN_AW    = OPC_W + STEP_W;
  localparam int SUB_AW     = SUB_W + STEP_W;
  localparam int MAIN_DEPTH = 2 ** MAIN_AW;
  localparam int SUB_DEPTH  = 2 ** SUB_AW;

  localparam int BIT_INC   = CW - 1;
  localparam int BIT_RST   = CW - 2;
  localparam int BIT_COND  = CW - 3;
  localparam int BIT_MERGE = CW - 4;

  localparam logic [STEP_W-1:0]    STEP_ZERO    = {STEP_W{1'b0}};
  localparam logic [STEP_W-1:0]    STEP_ONE     = {{(STEP_W-1){1'b0}}, 1'b1};
  localparam logic [STEP_W-1:0]    STEP_LAST    = {STEP_W{1'b1}};
  localparam logic [CW-1:0]        WORD_ZERO    = {CW{1'b0}};
  localparam logic [INSTRET_W-1:0] INSTRET_ZERO = {INSTRET_W{1'b0}};

  // What the step counter does at the next edge.
  typedef enum logic [2:0] {
    ACT_HOLD     = 3'd0,  // keep the step (stall or microcoded wait)
    ACT_ADVANCE  = 3'd1,  // step + 1
    ACT_FINISH   = 3'd2,  // back to step 0, instruction retires
    ACT_ABORT    = 3'd3,  // back to step 0, no retire (trap, RST at step 0)
    ACT_OVERFLOW = 3'd4   // INC past the last step: back to 0 with a fault
  } seq_act_e;

  // Microcode tables: plain register arrays, deliberately outside reset so a
  // loaded microcode image survives a core reset.
  logic [CW-1:0] main_mem_r [0:MAIN_DEPTH-1];
  logic [CW-1:0] sub_mem_r  [0:SUB_DEPTH-1];

  logic [STEP_W-1:0]    step_r;
  logic                 retire_r;
  logic                 fault_r;
  logic [INSTRET_W-1:0] instret_r;

  logic [MAIN_AW-1:0]   main_idx_s;
  logic [SUB_AW-1:0]    sub_idx_s;
  logic [SUB_AW-1:0]    sub_waddr_s;
  logic [CW-1:0]        main_word_s;
  logic [CW-1:0]        sub_word_s;
  logic [CW-1:0]        word_s;
  logic [CW-1:0]        ctrl_s;
  logic                 cond_taken_s;
  seq_act_e             act_s;
  logic [STEP_W-1:0]    step_nxt_s;
  logic                 retire_nxt_s;
  logic                 fault_nxt_s;

  assign main_idx_s  = {bus.opcode, step_r};
  assign sub_idx_s   = {bus.subop, step_r};
  // The sub table only decodes the low bits of the shared load address.
  assign sub_waddr_s = bus.ucode_addr[SUB_AW-1:0];

  // Microcode table load port; a write becomes visible to the read next cycle.
  always_ff @(posedge clk) begin
    if (bus.ucode_we) begin
      if (bus.ucode_sel) begin
        sub_mem_r[sub_waddr_s] <= bus.ucode_wdata;
      end else begin
        main_mem_r[bus.ucode_addr] <= bus.ucode_wdata;
      end
    end
  end

  // Control word selection: fetch word at step 0, table word (with optional
  // sub-table merge) afterwards, forced to zero while a trap is signalled.
  always_comb begin
    main_word_s = main_mem_r[main_idx_s];
    sub_word_s  = sub_mem_r[sub_idx_s];
    word_s      = FETCH_WORD;
    ctrl_s      = WORD_ZERO;
    if (step_r == STEP_ZERO) begin
      word_s = FETCH_WORD;
    end else if (main_word_s[BIT_MERGE]) begin
      word_s = main_word_s | sub_word_s;
    end else begin
      word_s = main_word_s;
    end
    if (bus.trap_in) begin
      ctrl_s = WORD_ZERO;
    end else begin
      ctrl_s = word_s;
    end
  end

  // A zeroed (trapped) word carries no COND bit, so cond_taken drops too.
  assign cond_taken_s = ctrl_s[BIT_COND] & bus.cond_in;

  // Sequencing decision, in priority order: trap, stall, COND, RST, INC.
  always_comb begin
    act_s = ACT_HOLD;
    if (bus.trap_in) begin
      act_s = ACT_ABORT;
    end else if (bus.stall_in) begin
      act_s = ACT_HOLD;
    end else if (word_s[BIT_COND]) begin
      if (bus.cond_in) begin
        act_s = ACT_ADVANCE;
      end else begin
        act_s = ACT_FINISH;
      end
    end else if (word_s[BIT_RST]) begin
      if (step_r != STEP_ZERO) begin
        act_s = ACT_FINISH;
      end else begin
        act_s = ACT_ABORT;
      end
    end else if (word_s[BIT_INC]) begin
      if (step_r == STEP_LAST) begin
        act_s = ACT_OVERFLOW;
      end else begin
        act_s = ACT_ADVANCE;
      end
    end else begin
      act_s = ACT_HOLD;
    end
  end

  // Next step and pulse values for the chosen action.
  always_comb begin
    step_nxt_s   = step_r;
    retire_nxt_s = 1'b0;
    fault_nxt_s  = 1'b0;
    case (act_s)
      ACT_HOLD: begin
        step_nxt_s = step_r;
      end
      ACT_ADVANCE: begin
        // A taken COND on the last step wraps naturally to step 0.
        step_nxt_s = step_r + STEP_ONE;
      end
      ACT_FINISH: begin
        step_nxt_s   = STEP_ZERO;
        retire_nxt_s = 1'b1;
      end
      ACT_ABORT: begin
        step_nxt_s = STEP_ZERO;
      end
      ACT_OVERFLOW: begin
        step_nxt_s  = STEP_ZERO;
        fault_nxt_s = 1'b1;
      end
      default: begin
        // Unreachable encodings recover to a clean fetch.
        step_nxt_s = STEP_ZERO;
      end
    endcase
  end

  // Step counter, one-cycle pulses and retired-instruction count. instret
  // moves on the same edge that raises retire, so both show together.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_r    <= STEP_ZERO;
      retire_r  <= 1'b0;
      fault_r   <= 1'b0;
      instret_r <= INSTRET_ZERO;
    end else begin
      step_r    <= step_nxt_s;
      retire_r  <= retire_nxt_s;
      fault_r   <= fault_nxt_s;
      instret_r <= instret_r + {{(INSTRET_W-1){1'b0}}, retire_nxt_s};
    end
  end

  assign bus.ctrl        = ctrl_s;
  assign bus.step        = step_r;
  assign bus.cond_taken  = cond_taken_s;
  assign bus.ucode_fault = fault_r;
  assign bus.retire      = retire_r;
  assign bus.instret     = instret_r;

endmodule

// File: doc/useq_sequencer.md
Name: useq_sequencer

Overview:
- Parametrised microcode sequencer for the multi-cycle TTL RISC-V core. Next generation of the hard-coded control-line ROM.
- Drives one control word per cycle from a step counter and writable main/sub microcode tables indexed by opcode/func3.
- Adds stall, conditional sequencing, a step-overflow fault and a runtime microcode load port.
- The datapath (PC, regfile, ALU, CSR) consumes `ctrl`; trap detection stays outside and feeds `trap_in`.

Parameters:
- CW, 32: control word width; the top 4 bits are sequencing bits.
- STEPS, 8: steps per instruction (power of 2, ≥2); STEP_W = clog2(STEPS).
- OPC_W, 5: opcode index width.
- SUB_W, 3: sub-op (func3) index width.
- INSTRET_W, 64: retired-instruction counter width.
- FETCH_WORD, 32'h8000_0045: step-0 control word, common to all opcodes; must have INC set.

Ports:
- clk, in, 1: clock.
- reset, in, 1: reset, synchronous, active-high.
- opcode, in, OPC_W: decoded opcode; stable while step ≥1.
- subop, in, SUB_W: sub-op index (func3); stable while step ≥1.
- cond_in, in, 1: branch comparison result.
- stall_in, in, 1: hold the current step (memory wait).
- trap_in, in, 1: trap; abort the instruction.
- ctrl, out, CW: current control word.
- step, out, STEP_W: current step.
- cond_taken, out, 1: a COND word is active and cond_in=1.
- ucode_fault, out, 1: one-cycle pulse on step overflow.
- retire, out, 1: one-cycle pulse when an instruction completes.
- instret, out, INSTRET_W: retired count.
- ucode_we, in, 1: table write strobe.
- ucode_sel, in, 1: 0 = main table, 1 = sub table.
- ucode_addr, in, OPC_W+STEP_W: {index, step}; the sub table uses the low SUB_W+STEP_W bits.
- ucode_wdata, in, CW: word to write.

Behaviour:
- Sequencing bits of a word: [CW-1] INC, [CW-2] RST, [CW-3] COND, [CW-4] MERGE.
- Word selection (combinational):
  - step==0: word = FETCH_WORD.
  - step ≥1: m = main[{opcode,step}]; word = m | sub[{subop,step}] if m.MERGE, else m.
  - ctrl = word, except ctrl = 0 while trap_in=1.
- Next step at posedge, in priority order:
  1. reset: step←0, instret←0, pulses low.
  2. trap_in: step←0; no retire.
  3. stall_in: hold step; no retire, no fault.
  4. COND: cond_in ? step+1 : step←0 with retire.
  5. RST (wins over INC): step←0; retire if step≠0.
  6. INC: step+1. If step==STEPS-1, instead step←0, ucode_fault=1, no retire.
  7. No sequencing bit set: hold step (microcoded wait).
- Pulses: retire and ucode_fault are registered and high for exactly the cycle after the transition. `instret` increments by 1 on each retire and wraps modulo 2^INSTRET_W.
- COND and INC/RST bits in the same word: COND governs; INC/RST are ignored.
- Tables:
  - Registers/LUT RAM of 2^(OPC_W+STEP_W) and 2^(SUB_W+STEP_W) words.
  - Written at posedge when ucode_we=1, regardless of run state. A write is visible to the combinational read from the next cycle.
  - Unaffected by reset; simulation initial value is 0.
  - Step-0 entries exist but are never read.
- After reset: step=0, ctrl=FETCH_WORD, cond_taken=0, ucode_fault=0, retire=0, instret=0.
- Latency: a step's word is valid in the same cycle as `step`; the step changes one cycle after its word is presented.

Test Plan:
- Reset, then 3 idle clocks with main[op 5'b01101, step1]=RST|0x20A -> ctrl alternates 0x80000045/0x4000020A; retire pulses every 2 cycles; instret=3 after 6 cycles.
- Branch word COND at step3: cond_in=1 -> step 4; cond_in=0 -> step 0, retire=1, cond_taken=0.
- stall_in held 4 cycles at step 2 -> step stays 2, ctrl unchanged, instret unchanged; resumes to step 3 on release.
- trap_in at step 3 -> ctrl=0 that cycle; next cycle step=0, ctrl=FETCH_WORD; no retire.
- main[op,7]=INC (STEPS=8) -> step 7→0, ucode_fault high 1 cycle, instret unchanged.
- MERGE: main=MERGE|0x10, sub[subop 3'b010,1]=RST|0x400 -> ctrl=0x50000410; step returns to 0. Rewrite the sub entry via ucode_we -> the new value appears the next cycle.
